cdr_lock_ctrl: RTL and testbench

- Acquisition/tracking sequencer for the baud-rate Mueller-Muller CDR loop.
- Watches the phase-detector output f_n on each symbol strobe (sample_en) and clears the PI loop on start.
- Gear-shifts the PI gains from fast acquisition to slow tracking, and asserts locked.
- Detects loss of lock and re-acquires.
- Sits beside the loop filter. Its kp_shift/ki_shift/loop_clear/loop_freeze outputs drive a gain-programmable PI.

---
 rtl/cdr_pkg.sv | 34 +++
 rtl/cdr_err_window.sv | 56 +++++
 rtl/cdr_lock_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_cdr_lock_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdr_pkg.sv
// Shared definitions for the CDR loop: state codes, gain-shift width and the
// default acquisition/tracking shifts used by both the PI filter and the
// lock sequencer.
package cdr_pkg;

    localparam int GAIN_W = 5;
    localparam int CNT_W  = 16;

    localparam logic [GAIN_W-1:0] KP_ACQ_DEF = 5'd8;
    localparam logic [GAIN_W-1:0] KI_ACQ_DEF = 5'd14;
    localparam logic [GAIN_W-1:0] KP_TRK_DEF = 5'd12;
    localparam logic [GAIN_W-1:0] KI_TRK_DEF = 5'd18;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACQ   = 3'd2,
        ST_TRACK = 3'd3,
        ST_HOLD  = 3'd4
    } cdr_state_e;

    // |v| clipped to 15 bits so that -32768 maps to 32767 instead of wrapping.
    function automatic logic [14:0] abs_sat15(input logic signed [15:0] v);
        logic [15:0] neg;
        neg = 16'(-v);
        if (v == 16'sh8000)
            return 15'h7fff;
        else if (v < 0)
            return neg[14:0];
        else
            return v[14:0];
    endfunction

endpackage

// File: rtl/cdr_err_window.sv
// Phase-error window meter: accumulates saturated |f_n| over 2^WIN_LOG2
// symbol strobes and classifies each completed window as quiet or noisy.
// win_done/quiet/noisy are combinational on the completing strobe so the
// sequencer can act at the same clock edge that latches win_sum.
module cdr_err_window
    import cdr_pkg::*;
#(
    parameter int WIN_LOG2   = 6,
    parameter int LOCK_THR   = 1024,
    parameter int UNLOCK_THR = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    sample_en,
    input  logic signed [15:0]      f_n,
    output logic                    win_done,
    output logic [15+WIN_LOG2-1:0]  win_sum,
    output logic                    quiet,
    output logic                    noisy
);

    localparam int SUM_W = 15 + WIN_LOG2;

    logic [WIN_LOG2-1:0] sym_cnt;
    logic [SUM_W-1:0]    acc;
    logic [SUM_W-1:0]    sum_next;
    logic [14:0]         mag;

    assign mag      = abs_sat15(f_n);
    assign sum_next = acc + SUM_W'(mag);
    assign win_done = sample_en && !clr && (&sym_cnt);
    assign quiet    = (sum_next <= SUM_W'(LOCK_THR));
    assign noisy    = (sum_next >  SUM_W'(UNLOCK_THR));

    // Accumulate per strobe; on the last symbol latch the total and restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt <= '0;
            acc     <= '0;
            win_sum <= '0;
        end else if (clr) begin
            sym_cnt <= '0;
            acc     <= '0;
        end else if (sample_en) begin
            sym_cnt <= sym_cnt + 1'b1;
            if (&sym_cnt) begin
                win_sum <= sum_next;
                acc     <= '0;
            end else begin
                acc <= sum_next;
            end
        end
    end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// Acquisition/tracking sequencer for the Mueller-Muller CDR loop. Clears the
// PI loop, runs fast gains until the phase error goes quiet, gear-shifts to
// tracking gains and reports lock, and re-acquires on loss of lock.
// Optional holdover (macro CDR_LOCK_CTRL_HOLDOVER_EN): loss of lock freezes
// the loop in HOLD for up to HOLD_WINS windows before falling back to CLEAR.
module cdr_lock_ctrl
    import cdr_pkg::*;
#(
    parameter int                WIN_LOG2         = 6,
    parameter int                LOCK_THR         = 1024,
    parameter int                UNLOCK_THR       = 4096,
    parameter int                LOCK_WINS        = 4,
    parameter int                UNLOCK_WINS      = 2,
    parameter int                ACQ_TIMEOUT_WINS = 255,
    parameter int                CLR_CYC          = 8,
    parameter logic [GAIN_W-1:0] KP_ACQ           = KP_ACQ_DEF,
    parameter logic [GAIN_W-1:0] KI_ACQ           = KI_ACQ_DEF,
    parameter logic [GAIN_W-1:0] KP_TRK           = KP_TRK_DEF,
    parameter logic [GAIN_W-1:0] KI_TRK           = KI_TRK_DEF
`ifdef CDR_LOCK_CTRL_HOLDOVER_EN
    ,
    parameter int                HOLD_WINS        = 8
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    sample_en,
    input  logic signed [15:0]      f_n,
    output logic                    loop_clear,
    output logic                    loop_freeze,
    output logic [GAIN_W-1:0]       kp_shift,
    output logic [GAIN_W-1:0]       ki_shift,
    output logic                    locked,
    output logic                    acq_fail,
    output logic [2:0]              state,
    output logic [15+WIN_LOG2-1:0]  win_sum
);

    cdr_state_e        state_q, state_d;
    logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0]  quiet_cnt_q, quiet_cnt_d;
    logic [CNT_W-1:0]  noisy_cnt_q, noisy_cnt_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
`ifdef CDR_LOCK_CTRL_HOLDOVER_EN
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
`endif
    logic              acq_fail_d, locked_d, loop_clear_d, loop_freeze_d;
    logic [GAIN_W-1:0] kp_d, ki_d;
    logic              win_clr, win_done, quiet, noisy;

    // The window only measures while the loop is actually running.
    assign win_clr = !enable || (state_q == ST_IDLE) || (state_q == ST_CLEAR);
    assign state   = state_q;

    cdr_err_window #(
        .WIN_LOG2   (WIN_LOG2),
        .LOCK_THR   (LOCK_THR),
        .UNLOCK_THR (UNLOCK_THR)
    ) u_win (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (win_clr),
        .sample_en (sample_en),
        .f_n       (f_n),
        .win_done  (win_done),
        .win_sum   (win_sum),
        .quiet     (quiet),
        .noisy     (noisy)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clr_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            noisy_cnt_q <= '0;
            win_cnt_q   <= '0;
`ifdef CDR_LOCK_CTRL_HOLDOVER_EN
            hold_cnt_q  <= '0;
`endif
            acq_fail    <= 1'b0;
            locked      <= 1'b0;
            loop_clear  <= 1'b0;
            loop_freeze <= 1'b0;
            kp_shift    <= KP_ACQ;
            ki_shift    <= KI_ACQ;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            noisy_cnt_q <= noisy_cnt_d;
            win_cnt_q   <= win_cnt_d;
`ifdef CDR_LOCK_CTRL_HOLDOVER_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
            acq_fail    <= acq_fail_d;
            locked      <= locked_d;
            loop_clear  <= loop_clear_d;
            loop_freeze <= loop_freeze_d;
            kp_shift    <= kp_d;
            ki_shift    <= ki_d;
        end
    end

    // Next state from window results; outputs decoded from the next state so
    // they change in the same cycle as the state register.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = '0;
        quiet_cnt_d = quiet_cnt_q;
        noisy_cnt_d = noisy_cnt_q;
        win_cnt_d   = win_cnt_q;
        acq_fail_d  = acq_fail;
`ifdef CDR_LOCK_CTRL_HOLDOVER_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        if (!enable) begin
            // enable low overrides everything, including a coincident window end
            state_d     = ST_IDLE;
            quiet_cnt_d = '0;
            noisy_cnt_d = '0;
            win_cnt_d   = '0;
            acq_fail_d  = 1'b0;
`ifdef CDR_LOCK_CTRL_HOLDOVER_EN
            hold_cnt_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CLEAR;
                ST_CLEAR: begin
                    quiet_cnt_d = '0;
                    noisy_cnt_d = '0;
                    win_cnt_d   = '0;
                    if (clr_cnt_q == CNT_W'(CLR_CYC - 1))
                        state_d = ST_ACQ;
                    else
                        clr_cnt_d = clr_cnt_q + 1'b1;
                end
                ST_ACQ: begin
                    if (win_done) begin
                        win_cnt_d   = win_cnt_q + 1'b1;
                        quiet_cnt_d = quiet ? quiet_cnt_q + 1'b1 : '0;
                        // lock takes priority over a timeout on the same window
                        if (quiet && (quiet_cnt_q + 1'b1 == CNT_W'(LOCK_WINS))) begin
                            state_d     = ST_TRACK;
                            quiet_cnt_d = '0;
                            win_cnt_d   = '0;
                        end else if (win_cnt_q + 1'b1 == CNT_W'(ACQ_TIMEOUT_WINS)) begin
                            state_d    = ST_CLEAR;
                            acq_fail_d = 1'b1;
                        end
                    end
                end
                ST_TRACK: begin
                    if (win_done) begin
                        if (noisy) begin
                            noisy_cnt_d = noisy_cnt_q + 1'b1;
                            if (noisy_cnt_q + 1'b1 == CNT_W'(UNLOCK_WINS)) begin
                                noisy_cnt_d = '0;
`ifdef CDR_LOCK_CTRL_HOLDOVER_EN
                                state_d    = ST_HOLD;
                                hold_cnt_d = '0;
`else
                                state_d = ST_CLEAR;
`endif
                            end
                        end else begin
                            noisy_cnt_d = '0;
                        end
                    end
                end
`ifdef CDR_LOCK_CTRL_HOLDOVER_EN
                ST_HOLD: begin
                    if (win_done) begin
                        if (quiet) begin
                            state_d    = ST_TRACK;
                            hold_cnt_d = '0;
                        end else if (hold_cnt_q + 1'b1 == CNT_W'(HOLD_WINS)) begin
                            state_d    = ST_CLEAR;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        locked_d      = (state_d == ST_TRACK);
        loop_clear_d  = (state_d == ST_CLEAR);
        loop_freeze_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
        kp_d          = KP_ACQ;
        ki_d          = KI_ACQ;
        if (state_d == ST_TRACK) begin
            kp_d = KP_TRK;
            ki_d = KI_TRK;
        end
`ifdef CDR_LOCK_CTRL_HOLDOVER_EN
        if (state_d == ST_HOLD) begin
            loop_freeze_d = 1'b1;
            kp_d          = KP_TRK;
            ki_d          = KI_TRK;
        end
`endif
    end

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Bench for cdr_lock_ctrl. Stimulus pushes the expected sequence of output
// snapshots (with the cycle they must appear), window sums and loop_clear
// pulse lengths; a negedge monitor pops and compares whenever the DUT
// outputs change.
module tb_cdr_lock_ctrl;

    localparam logic [31:0] ANY_CYC = 32'hffff_ffff;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               sample_en;
    logic signed [15:0] f_n;
    logic               loop_clear, loop_freeze, locked, acq_fail;
    logic [4:0]         kp_shift, ki_shift;
    logic [2:0]         state;
    logic [20:0]        win_sum;

    cdr_lock_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sample_en   (sample_en),
        .f_n         (f_n),
        .loop_clear  (loop_clear),
        .loop_freeze (loop_freeze),
        .kp_shift    (kp_shift),
        .ki_shift    (ki_shift),
        .locked      (locked),
        .acq_fail    (acq_fail),
        .state       (state),
        .win_sum     (win_sum)
    );

    // Clock and cycle stamp
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    logic [16:0] obs_q[$];
    logic [31:0] obs_cyc_q[$];
    logic [20:0] sum_q[$];
    logic [31:0] sum_cyc_q[$];
    logic [31:0] clr_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic logic [16:0] mk(input logic [2:0] st, input logic lk, input logic fl,
                                       input logic cl, input logic fz,
                                       input logic [4:0] kp, input logic [4:0] ki);
        return {st, lk, fl, cl, fz, kp, ki};
    endfunction

    function automatic logic [16:0] rst_o();        return mk(3'd0, 0, 0, 0, 0, 5'd8, 5'd14);  endfunction
    function automatic logic [16:0] idle_o();       return mk(3'd0, 0, 0, 0, 1, 5'd8, 5'd14);  endfunction
    function automatic logic [16:0] clr_o(input logic f); return mk(3'd1, 0, f, 1, 1, 5'd8, 5'd14);  endfunction
    function automatic logic [16:0] acq_o(input logic f); return mk(3'd2, 0, f, 0, 0, 5'd8, 5'd14);  endfunction
    function automatic logic [16:0] trk_o(input logic f); return mk(3'd3, 1, f, 0, 0, 5'd12, 5'd18); endfunction
    function automatic logic [16:0] hold_o();       return mk(3'd4, 0, 0, 0, 1, 5'd12, 5'd18); endfunction

    task automatic exp_obs(input logic [16:0] o, input int lat);
        obs_q.push_back(o);
        obs_cyc_q.push_back((lat < 0) ? ANY_CYC : 32'(cyc + lat));
    endtask

    task automatic exp_sum(input logic [20:0] s, input int lat);
        sum_q.push_back(s);
        sum_cyc_q.push_back((lat < 0) ? ANY_CYC : 32'(cyc + lat));
    endtask

    // Expect CLEAR now+lat, then ACQ eight cycles later, with an 8-cycle clear pulse.
    task automatic exp_clear_cycle(input logic f, input int lat);
        exp_obs(clr_o(f), lat);
        exp_obs(acq_o(f), lat + 8);
        clr_q.push_back(32'd8);
    endtask

    // Monitor
    logic [16:0] prev_obs;
    logic [20:0] prev_sum;
    logic        have_obs = 1'b0;
    logic        have_sum = 1'b0;
    logic        clr_prev = 1'b0;
    int          clr_len  = 0;

    always @(negedge clk) begin
        logic [16:0] cur;
        logic [31:0] c;
        cur = {state, locked, acq_fail, loop_clear, loop_freeze, kp_shift, ki_shift};
        if (!have_obs || cur != prev_obs) begin
            if (obs_q.size() == 0) begin
                check("obs_unexpected_change", 32'(cur), 32'(prev_obs));
            end else begin
                check("obs", 32'(cur), 32'(obs_q.pop_front()));
                c = obs_cyc_q.pop_front();
                if (c != ANY_CYC) check("obs_cycle", 32'(cyc), c);
            end
        end
        prev_obs = cur;
        have_obs = 1'b1;

        if (!have_sum || win_sum != prev_sum) begin
            if (sum_q.size() == 0) begin
                check("win_sum_unexpected_change", 32'(win_sum), 32'(prev_sum));
            end else begin
                check("win_sum", 32'(win_sum), 32'(sum_q.pop_front()));
                c = sum_cyc_q.pop_front();
                if (c != ANY_CYC) check("win_sum_cycle", 32'(cyc), c);
            end
        end
        prev_sum = win_sum;
        have_sum = 1'b1;

        if (loop_clear) begin
            clr_len++;
        end else if (clr_prev) begin
            if (clr_q.size() == 0) check("clear_unexpected", 32'(clr_len), 32'd0);
            else                   check("clear_len", 32'(clr_len), clr_q.pop_front());
            clr_len = 0;
        end
        clr_prev = loop_clear;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic signed [15:0] v);
        sample_en = 1'b1;
        f_n       = v;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic run_win(input logic signed [15:0] a, input logic signed [15:0] b);
        for (int i = 0; i < 64; i++) sym(i[0] ? b : a);
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        sample_en = 1'b0;
        f_n       = '0;
        exp_obs(rst_o(), -1);
        exp_sum(21'd0, -1);
        repeat (3) tick();

        // Reset release in IDLE, then enable: 8-cycle clear, strobes ignored in CLEAR
        rst_n = 1'b1;
        exp_obs(idle_o(), 1);
        tick();
        enable = 1'b1;
        exp_clear_cycle(1'b0, 1);
        tick();
        repeat (8) sym(16'sd30000);

        // Four quiet windows (sum 512) -> TRACK with tracking gains
        for (int w = 0; w < 4; w++) begin
            run_win(16'sd8, -16'sd8);
            if (w == 0) exp_sum(21'd512, 0);
            if (w == 3) exp_obs(trk_o(1'b0), 0);
        end

        // Two noisy windows (sum 6400) -> loss of lock
        run_win(16'sd100, 16'sd100);
        exp_sum(21'd6400, 0);
        run_win(16'sd100, 16'sd100);
`ifdef CDR_LOCK_CTRL_HOLDOVER_EN
        exp_obs(hold_o(), 0);
        run_win(16'sd8, -16'sd8);
        exp_sum(21'd512, 0);
        exp_obs(trk_o(1'b0), 0);
        run_win(16'sd100, 16'sd100);
        exp_sum(21'd6400, 0);
        run_win(16'sd100, 16'sd100);
        exp_obs(hold_o(), 0);
        for (int w = 0; w < 8; w++) begin
            run_win(16'sd100, 16'sd100);
            if (w == 7) exp_clear_cycle(1'b0, 0);
        end
`else
        exp_clear_cycle(1'b0, 0);
`endif
        repeat (8) tick();

        // Acquisition timeout: 255 windows of sum 12800
        for (int w = 0; w < 255; w++) begin
            run_win(16'sd200, 16'sd200);
            if (w == 0)   exp_sum(21'd12800, 0);
            if (w == 254) exp_clear_cycle(1'b1, 0);
        end
        repeat (8) tick();

        // Lock again; acq_fail stays set
        for (int w = 0; w < 4; w++) begin
            run_win(16'sd8, -16'sd8);
            if (w == 0) exp_sum(21'd512, 0);
            if (w == 3) exp_obs(trk_o(1'b1), 0);
        end

        // Saturated magnitude, then quiet/middle windows resetting the noisy count
        run_win(-16'sd32768, -16'sd32768);
        exp_sum(21'd2097088, 0);
        run_win(16'sd8, -16'sd8);
        exp_sum(21'd512, 0);
        run_win(16'sd100, 16'sd100);
        exp_sum(21'd6400, 0);
        run_win(16'sd40, -16'sd40);
        exp_sum(21'd2560, 0);
        run_win(16'sd100, 16'sd100);
        exp_sum(21'd6400, 0);

        // enable falls on the strobe that would end a second noisy window
        repeat (63) sym(16'sd100);
        sample_en = 1'b1;
        f_n       = 16'sd100;
        enable    = 1'b0;
        tick();
        sample_en = 1'b0;
        exp_obs(idle_o(), 0);
        repeat (2) tick();

        // Re-acquire, then async reset mid-window
        enable = 1'b1;
        exp_clear_cycle(1'b0, 1);
        tick();
        repeat (8) tick();
        repeat (30) sym(16'sd8);
        exp_obs(rst_o(), 0);
        exp_sum(21'd0, 0);
        #2;
        rst_n = 1'b0;
        repeat (3) tick();

        check("obs_q_drained", 32'(obs_q.size()), 32'd0);
        check("sum_q_drained", 32'(sum_q.size()), 32'd0);
        check("clr_q_drained", 32'(clr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
